// File: rtl/mod_conversor_bcd_pkg.sv
// Shared sizing, FSM encoding and sign/magnitude helper for the 6-bit
// two's-complement to BCD converter.
package mod_conversor_bcd_pkg;

  localparam int DATA_WIDTH  = 6;
  localparam int BCD_DIGITS  = 2;
  localparam int SHIFT_COUNT = 6;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int CNT_W       = 3;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Unsigned 6-bit result keeps -32 as 32 instead of wrapping to 0.
  function automatic logic [DATA_WIDTH-1:0] magnitude_of(
    input logic [DATA_WIDTH-1:0] d,
    input logic                  neg
  );
    return neg ? (~d + DATA_WIDTH'(1)) : d;
  endfunction

endpackage

// File: rtl/mod_conversor_bcd_if.sv
// Request/result bundle between the ALU side and the BCD converter.
interface mod_conversor_bcd_if;
  import mod_conversor_bcd_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] dato;
  logic                  signed_mode;
  logic                  busy;
  logic                  done;
  logic                  signo;
  logic [3:0]            decenas;
  logic [3:0]            unidades;

  modport master (
    output start, dato, signed_mode,
    input  busy, done, signo, decenas, unidades
  );

  modport slave (
    input  start, dato, signed_mode,
    output busy, done, signo, decenas, unidades
  );

endinterface

// File: rtl/mod_conversor_bcd_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_adjust (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/mod_conversor_bcd.sv
// Sequential two's-complement/unsigned to sign + two-digit BCD converter
// using a 6-step double-dabble over a {BCD, magnitude} scratch register.
module mod_conversor_bcd
  import mod_conversor_bcd_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mod_conversor_bcd_if.slave  bus
);

  logic [1:0]                  r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_sign;
  logic [DATA_WIDTH-1:0]       r_mag;
  logic [BCD_W-1:0]            r_bcd;
  logic                        r_signo;
  logic [3:0]                  r_decenas;
  logic [3:0]                  r_unidades;

  logic                        w_neg;
  logic [BCD_W-1:0]            w_adj;
  logic [BCD_W+DATA_WIDTH-1:0] w_shift;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3_adjust u_adj (
      .i_nibble (r_bcd[4*g +: 4]),
      .o_nibble (w_adj[4*g +: 4])
    );
  end

  // Corrected digits and remaining magnitude shift as one vector.
  assign w_shift = {w_adj, r_mag} << 1;
  assign w_neg   = bus.signed_mode & bus.dato[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_bcd      <= '0;
      r_signo    <= 1'b0;
      r_decenas  <= '0;
      r_unidades <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sign  <= w_neg;
            r_mag   <= magnitude_of(bus.dato, w_neg);
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_shift[BCD_W+DATA_WIDTH-1:DATA_WIDTH];
          r_mag <= w_shift[DATA_WIDTH-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == SHIFT_LAST) begin
            r_state    <= ST_DONE;
            r_signo    <= r_sign;
            r_decenas  <= w_shift[BCD_W+DATA_WIDTH-1:DATA_WIDTH+4];
            r_unidades <= w_shift[DATA_WIDTH+3:DATA_WIDTH];
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.signo    = r_signo;
  assign bus.decenas  = r_decenas;
  assign bus.unidades = r_unidades;

endmodule

// File: tb/tb_mod_conversor_bcd.sv
// Scoreboard bench for mod_conversor_bcd: a decimal reference model queues
// expected results on accepted starts; a monitor checks every cycle.
module tb_mod_conversor_bcd;

  typedef struct {
    logic       signo;
    logic [3:0] dec;
    logic [3:0] uni;
  } exp_t;

  logic clk;
  logic reset;
  mod_conversor_bcd_if bus();

  mod_conversor_bcd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t last_exp;
  int   m_left = 0;   // cycles until the converter can accept a new start

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [5:0] d, input logic sm);
    exp_t e;
    int v, mag;
    v   = sm ? int'($signed(d)) : int'(d);
    mag = (v < 0) ? -v : v;
    e.signo = (v < 0);
    e.dec   = 4'(mag / 10);
    e.uni   = 4'(mag % 10);
    return e;
  endfunction

  // Reference model: a start is taken only when the previous conversion
  // (8 cycles including the idle re-sample) has fully finished.
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
    end else begin
      if (m_left > 0) m_left = m_left - 1;
      if (m_left == 0 && bus.start) begin
        exp_q.push_back(ref_model(bus.dato, bus.signed_mode));
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      last_exp = '{1'b0, 4'd0, 4'd0};
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_out", int'({bus.signo, bus.decenas, bus.unidades}), 0);
    end else begin
      chk("busy", int'(bus.busy), int'(m_left >= 2));
      chk("done", int'(bus.done), int'(m_left == 2));
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("signo", int'(bus.signo), int'(e.signo));
          chk("decenas", int'(bus.decenas), int'(e.dec));
          chk("unidades", int'(bus.unidades), int'(e.uni));
          last_exp = e;
        end
      end else begin
        chk("hold_out", int'({bus.signo, bus.decenas, bus.unidades}),
            int'({last_exp.signo, last_exp.dec, last_exp.uni}));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input logic [5:0] d, input logic sm);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dato        = d;
    bus.signed_mode = sm;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_now_busy", int'(bus.busy), 0);
    chk("rst_now_done", int'(bus.done), 0);
    chk("rst_now_out", int'({bus.signo, bus.decenas, bus.unidades}), 0);
    idle(hold);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.dato        = '0;
    bus.signed_mode = 1'b0;
    #1;
    chk("por_busy", int'(bus.busy), 0);
    chk("por_out", int'({bus.signo, bus.decenas, bus.unidades}), 0);
    idle(3);
    #2 reset = 1'b0;

    // Directed corner values
    pulse(6'b100000, 1'b1); idle(9);
    pulse(6'b111111, 1'b1); idle(9);
    pulse(6'b011111, 1'b1); idle(9);
    pulse(6'b111111, 1'b0); idle(9);
    pulse(6'b000000, 1'b0); idle(9);
    pulse(6'b000000, 1'b1); idle(9);

    // Start and input changes while busy are ignored
    pulse(6'd5, 1'b0);
    idle(1);
    bus.start = 1'b1; bus.dato = 6'd9; bus.signed_mode = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dato  = 6'd63;
    idle(10);

    // Reset mid-conversion aborts; no done afterwards
    pulse(6'd37, 1'b0);
    idle(3);
    do_reset(2);
    idle(12);

    // Start already high when reset releases is taken on the first edge
    @(negedge clk);
    #2 reset = 1'b1;
    bus.start = 1'b1; bus.dato = 6'd17; bus.signed_mode = 1'b0;
    idle(2);
    #2 reset = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    idle(10);

    // Start held high: back-to-back conversions every 8 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.dato = 6'd42; bus.signed_mode = 1'b0;
    idle(25);
    bus.start = 1'b0;
    idle(10);

    // Random start/data traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.dato        = 6'($urandom);
      bus.signed_mode = 1'($urandom);
    end
    bus.start = 1'b0;

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_conversor_bcd.md
MOD_CONVERSOR_BCD -- requirements
Module: mod_conversor_bcd

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL expose: clk  input  1  system clock, rising edge.
REQ-003 SHALL expose: reset  input  1  asynchronous active-high reset.
REQ-004 SHALL expose: start  input  1  request conversion of dato; sampled only in IDLE.
REQ-005 SHALL expose: dato  input  6  ALU result, two's complement when signed_mode=1, unsigned otherwise.
REQ-006 SHALL expose: signed_mode  input  1  1 = signed interpretation, 0 = unsigned; sampled with start.
REQ-007 SHALL expose: busy  output  1  high from the capture edge until done deasserts.
REQ-008 SHALL expose: done  output  1  one-cycle pulse; results valid from this cycle.
REQ-009 SHALL expose: signo  output  1  1 = negative result (minus segment on display).
REQ-010 SHALL expose: decenas  output  4  BCD tens digit of magnitude, range 0..6.
REQ-011 SHALL expose: unidades  output  4  BCD units digit of magnitude, range 0..9.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; no other reachable states.
REQ-013 IDLE with start=1 at a rising edge SHALL capture: sign = signed_mode & dato[5]; magnitude = sign ? (~dato + 1) mod 64 : dato; clear BCD scratch and shift counter; go to SHIFT.
REQ-014 Magnitude of dato=6'b100000 in signed mode SHALL be 32 (6-bit unsigned), not truncated to 0.
REQ-015 SHIFT SHALL run exactly 6 cycles of double-dabble: per cycle, each BCD nibble >=5 gets +3, then {BCD, magnitude} shifts left by 1.
REQ-016 After the 6th SHIFT edge the FSM SHALL enter DONE; at that same edge signo, decenas, unidades SHALL be loaded from the final scratch registers.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the 7th cycle after the start-capture edge (capture edge = cycle 0).
REQ-019 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-020 start asserted while busy=1 SHALL be ignored (not queued); dato/signed_mode changes during conversion SHALL not affect the result.
REQ-021 start held continuously high SHALL cause back-to-back conversions, one per 8 cycles (IDLE re-samples).
REQ-022 signo, decenas, unidades SHALL hold their last values until the next DONE-entry edge.
REQ-023 Unsigned mode SHALL force signo=0 regardless of dato[5].
REQ-024 Zero result SHALL yield signo=0, decenas=0, unidades=0 (no negative zero possible).

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, busy=0, done=0, signo=0, decenas=0, unidades=0, scratch and counter=0.
REQ-026 Reset mid-conversion SHALL abort it; no done pulse SHALL follow release; outputs SHALL stay 0 until a new conversion completes.
REQ-027 First start SHALL be honoured at the first rising edge after reset deasserts.

Structure
REQ-028 Shared package SHALL hold DATA_WIDTH=6, BCD_DIGITS=2, SHIFT_COUNT=6 and the FSM state encoding.
REQ-029 Per-nibble add-3 adjust SHALL be a sub-module bcd_add3_adjust (4-bit in, 4-bit out, combinational), instantiated per digit.
REQ-030 All state SHALL be in a single clocked process with async reset; no latches.

Verification
REQ-031 signed_mode=1, dato=6'b100000, start pulse -> 7 cycles later done=1, signo=1, decenas=3, unidades=2.
REQ-032 signed_mode=1, dato=6'b111111 -> signo=1, decenas=0, unidades=1; signed_mode=1, dato=6'b011111 -> signo=0, 3, 1.
REQ-033 signed_mode=0, dato=6'b111111 -> signo=0, decenas=6, unidades=3; dato=0 -> 0, 0, 0.
REQ-034 Start with dato=5, then start pulse with dato=9 at cycle 3 -> single done at cycle 7 with 0,0,5; no second done.
REQ-035 Reset asserted at cycle 4 of a conversion -> outputs 0 at once, no done within 10 cycles after release.
REQ-036 start held high, dato=6'd42 unsigned -> done pulses at cycles 7, 15, 23, each with 0,4,2; busy low only one cycle between.
